// File: rtl/ysyx_25020047_dmem_resp_if.sv
// Load/store request and response channel between the LSU (master) and the data-memory responder (slave).
interface ysyx_25020047_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_25020047_dmem_resp.sv
// Fixed-latency word-array data memory answering one byte/half/word load or store at a time.
// Optional macro YSYX_25020047_DMEM_RAND_DELAY_EN adds 0..3 cycles of LFSR-chosen extra latency.
module ysyx_25020047_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_25020047_dmem_resp_if.slave bus
);
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W     = 5;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic               wen_q;
  logic [31:0]        wdata_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               ready_q;
  logic               valid_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               idle_c;
  logic               accept_c;
  logic               fire_c;
  logic [CNT_W-1:0]   lat_c;
  logic [31:0]        acc_addr_c;
  logic               acc_wen_c;
  logic [31:0]        acc_wdata_c;
  logic [1:0]         acc_size_c;
  logic               acc_uns_c;
  logic [31:0]        offset_c;
  logic               err_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        rword_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        ld_c;
  logic [31:0]        resp_data_c;
  logic [3:0]         be_c;
  logic [31:0]        wrep_c;
  logic [31:0]        wmerge_c;
  logic               mem_we_c;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign idle_c   = (state_q == IDLE);
  assign accept_c = idle_c && bus.req_valid;

`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, stepped after each acceptance has used the current value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h5A;
    end else if (accept_c) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_c = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_c = CNT_W'(LATENCY);
`endif

  // A latency-1 request is serviced straight from the bus on its acceptance edge
  assign fire_c = (accept_c && (lat_c == CNT_W'(1))) || ((state_q == WAIT) && (cnt_q == '0));

  assign acc_addr_c  = idle_c ? bus.req_addr     : addr_q;
  assign acc_wen_c   = idle_c ? bus.req_wen      : wen_q;
  assign acc_wdata_c = idle_c ? bus.req_wdata    : wdata_q;
  assign acc_size_c  = idle_c ? bus.req_size     : size_q;
  assign acc_uns_c   = idle_c ? bus.req_unsigned : uns_q;

  // Address decode, load extraction and store lane merge
  always_comb begin
    offset_c    = acc_addr_c - BASE_ADDR;
    err_c       = ({1'b0, offset_c} >= MEM_BYTES)
               || (acc_size_c == 2'd3)
               || ((acc_size_c == 2'd1) && acc_addr_c[0])
               || ((acc_size_c == 2'd2) && (acc_addr_c[1:0] != 2'b00));
    idx_c       = offset_c[IDX_W+1:2];
    rword_c     = mem[idx_c];
    byte_c      = rword_c[{acc_addr_c[1:0], 3'b000} +: 8];
    half_c      = rword_c[{acc_addr_c[1], 4'b0000} +: 16];
    ld_c        = rword_c;
    be_c        = 4'b1111;
    wrep_c      = acc_wdata_c;
    case (acc_size_c)
      2'd0: begin
        ld_c   = acc_uns_c ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
        be_c   = 4'b0001 << acc_addr_c[1:0];
        wrep_c = {4{acc_wdata_c[7:0]}};
      end
      2'd1: begin
        ld_c   = acc_uns_c ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
        be_c   = acc_addr_c[1] ? 4'b1100 : 4'b0011;
        wrep_c = {2{acc_wdata_c[15:0]}};
      end
      default: ;
    endcase
    for (int b = 0; b < 4; b++) begin
      wmerge_c[b*8 +: 8] = be_c[b] ? wrep_c[b*8 +: 8] : rword_c[b*8 +: 8];
    end
    resp_data_c = (err_c || acc_wen_c) ? 32'h0 : ld_c;
    mem_we_c    = fire_c && acc_wen_c && !err_c && !rst;
  end

  // Array is deliberately left out of reset so contents survive it
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= wmerge_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wen_q   <= bus.req_wen;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            ready_q <= 1'b0;
            if (fire_c) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              rdata_q <= resp_data_c;
              err_q   <= err_c;
            end else begin
              state_q <= WAIT;
              cnt_q   <= lat_c - CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (fire_c) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            rdata_q <= resp_data_c;
            err_q   <= err_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_dmem_resp.sv
// Directed bench for ysyx_25020047_dmem_resp: byte/half/word access, errors, backpressure, reset.
module tb_ysyx_25020047_dmem_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] rd;
  logic        er;
  int          lt;

  ysyx_25020047_dmem_resp_if bus();

  ysyx_25020047_dmem_resp #(
    .DEPTH_WORDS(1024),
    .LATENCY(2),
    .BASE_ADDR(32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // One full transaction; lat counts cycles from the acceptance edge to resp_valid (50 = timeout)
  task automatic do_req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat);
    bus.req_addr     = addr;
    bus.req_wen      = wen;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata: got %h expected 00000000", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, rd, er, lt);
    checks++; if (lt !== 2) begin failures++; $display("FAIL sw_latency: got %0d expected 2", lt); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata: got %h expected 00000000", rd); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL sw_back_to_idle: req_ready got %b expected 1", bus.req_ready); end
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (lt !== 2) begin failures++; $display("FAIL lw_latency: got %0d expected 2", lt); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL lw_err: got %b expected 0", er); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte();
    do_req(32'h8000_0011, 1'b1, 32'h0000_0080, 2'd0, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL sb_err: got %b expected 0", er); end
    do_req(32'h8000_0011, 1'b0, 32'h0, 2'd0, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    do_req(32'h8000_0011, 1'b0, 32'h0, 2'd0, 1'b1, rd, er, lt);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu: got %h expected 00000080", rd); end
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'hDEAD_80EF) begin failures++; $display("FAIL lw_after_sb: got %h expected dead80ef", rd); end
  endtask

  task automatic test_half();
    do_req(32'h8000_0012, 1'b1, 32'h0000_1234, 2'd1, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL sh_err: got %b expected 0", er); end
    do_req(32'h8000_0012, 1'b0, 32'h0, 2'd1, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'h0000_1234) begin failures++; $display("FAIL lh_upper: got %h expected 00001234", rd); end
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd1, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'hFFFF_80EF) begin failures++; $display("FAIL lh_lower_signed: got %h expected ffff80ef", rd); end
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd1, 1'b1, rd, er, lt);
    checks++; if (rd !== 32'h0000_80EF) begin failures++; $display("FAIL lhu_lower: got %h expected 000080ef", rd); end
    do_req(32'h8000_0013, 1'b0, 32'h0, 2'd0, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'h0000_0012) begin failures++; $display("FAIL lb_lane3: got %h expected 00000012", rd); end
    do_req(32'h8000_0013, 1'b0, 32'h0, 2'd1, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL lh_misaligned_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL lh_misaligned_rdata: got %h expected 00000000", rd); end
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'h1234_80EF) begin failures++; $display("FAIL lw_after_sh: got %h expected 123480ef", rd); end
  endtask

  task automatic test_errors();
    do_req(32'h8000_0FFC, 1'b1, 32'hCAFE_F00D, 2'd2, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL sw_last_err: got %b expected 0", er); end
    do_req(32'h7FFF_FFFC, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL below_base_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL below_base_rdata: got %h expected 00000000", rd); end
    do_req(32'h8000_1000, 1'b1, 32'h1111_1111, 2'd2, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL past_end_err: got %b expected 1", er); end
    do_req(32'h8000_0FFE, 1'b1, 32'h2222_2222, 2'd2, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL sw_misaligned_err: got %b expected 1", er); end
    do_req(32'h8000_0FFC, 1'b1, 32'h3333_3333, 2'd3, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL size3_err: got %b expected 1", er); end
    do_req(32'h8000_0FFC, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL lw_last_err: got %b expected 0", er); end
    checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw_last_unchanged: got %h expected cafef00d", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    bus.req_addr     = 32'h8000_0010;
    bus.req_wen      = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL bp_latency: got %0d expected 2", n); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", c, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== 32'h1234_80EF) begin failures++; $display("FAIL bp_rdata_hold[%0d]: got %h expected 123480ef", c, bus.resp_rdata); end
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", c, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_reset_midway();
    do_req(32'h8000_0020, 1'b1, 32'h55AA_55AA, 2'd2, 1'b0, rd, er, lt);
    bus.req_addr  = 32'h8000_0020;
    bus.req_wen   = 1'b1;
    bus.req_wdata = 32'h0000_0001;
    bus.req_size  = 2'd2;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL midwait_rst_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL midwait_rst_valid: got %b expected 0", bus.resp_valid); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL dropped_no_resp: got %b expected 0", bus.resp_valid); end
    do_req(32'h8000_0020, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'h55AA_55AA) begin failures++; $display("FAIL dropped_store: got %h expected 55aa55aa", rd); end
    // Reset while a load response is being held
    bus.req_addr  = 32'h8000_0020;
    bus.req_wen   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL midresp_pre_valid: got %b expected 1", bus.resp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL midresp_rst_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL midresp_rst_rdata: got %h expected 00000000", bus.resp_rdata); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL midresp_rst_ready: got %b expected 1", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(32'h8000_0010, 1'b0, 32'h0, 2'd2, 1'b0, rd, er, lt);
    checks++; if (rd !== 32'h1234_80EF) begin failures++; $display("FAIL mem_survives_rst: got %h expected 123480ef", rd); end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wen      = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.resp_ready   = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25020047_dmem_resp.md
YSYX_25020047_DMEM_RESP -- requirements
Module: ysyx_25020047_dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req_valid  input  1  load/store request present.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_addr  input  32  byte address, the address computed by the EXU.
REQ-009 req_wen  input  1  1 = store, 0 = load.
REQ-010 req_wdata  input  32  store data; the byte/half is taken from bits [7:0]/[15:0].
REQ-011 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-012 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  requester takes the response.
REQ-015 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 resp_err  output  1  request was out of range, misaligned or illegal.

Function
REQ-017 FSM states: IDLE, WAIT and RESP.
- IDLE: req_ready=1, resp_valid=0.
- WAIT: req_ready=0, resp_valid=0.
- RESP: req_ready=0, resp_valid=1.
REQ-018 IDLE with req_valid=1 shall capture addr, wen, wdata, size and unsigned, load the counter with latency-1, and go to WAIT, or go directly to RESP when the latency is 1.
REQ-019 WAIT shall decrement the counter each cycle; on the cycle the counter is 0 it shall perform the access and go to RESP.
- Result: resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 RESP shall hold resp_valid, resp_rdata and resp_err stable until resp_ready=1; on that cycle the FSM returns to IDLE.
REQ-021 There is no request overlap: at least one IDLE cycle separates consecutive acceptances.
REQ-022 Error conditions:
- offset = addr-BASE_ADDR, unsigned, is >= DEPTH_WORDS*4;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- size=3.
REQ-023 An erroring request shall set resp_err=1 and resp_rdata=0, and shall not modify memory.
REQ-024 The word index shall be offset[31:2].
- Byte lane: addr[1:0].
- Half lane: addr[1].
REQ-025 A store shall write only the addressed lanes.
- Byte: 1 lane.
- Half: 2 lanes.
- Word: 4 lanes.
- Unaddressed lanes are unchanged.
- The write occurs exactly once, on the WAIT-to-RESP (or IDLE-to-RESP) edge.
REQ-026 A load shall select the addressed byte or half and extend it to 32 bits per req_unsigned; req_unsigned is ignored for word loads.
REQ-027 A load that follows a store to the same address shall return the stored data.

Reset
REQ-028 Assertion of rst at any time, including mid-WAIT or mid-RESP, shall immediately force:
- state IDLE, counter 0;
- req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 A request interrupted by reset shall be dropped with no response.
- A store that has not reached its write edge is not performed.
REQ-030 Memory array contents are not affected by reset.

Configuration
REQ-031 Macro YSYX_25020047_DMEM_RAND_DELAY_EN.
- Defined: effective latency = LATENCY + lfsr[1:0], range LATENCY..LATENCY+3.
- lfsr is an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'h5A on reset.
- The LFSR advances once per accepted request, after its value is sampled.
REQ-032 Undefined: latency is exactly LATENCY and no LFSR exists.

Verification
REQ-033 Default parameters, store word 0x8000_0010 data 0xDEADBEEF, then load word 0x8000_0010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after each acceptance.
REQ-034 After REQ-033, store byte 0x8000_0011 data 0x0000_0080, then:
- load byte signed 0x8000_0011 -> 0xFFFF_FF80;
- load byte unsigned 0x8000_0011 -> 0x0000_0080;
- load word 0x8000_0010 -> 0xDEAD_80EF.
REQ-035 Store half 0x8000_0012 data 0x1234, then load half signed 0x8000_0012 -> 0x0000_1234; then load half 0x8000_0013 -> resp_err=1, rdata=0.
REQ-036 Load 0x7FFF_FFFC, and separately store to 0x8000_1000 (DEPTH 1024) -> resp_err=1 for both, and a later load of 0x8000_0FFC is unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable throughout, req_ready=0; then resp_ready=1 -> IDLE the next cycle.
REQ-038 Assert rst 1 cycle after accepting a store word 0x8000_0020 data 0x1 -> no response, req_ready=1 immediately, and a later load returns the prior value.
